// File: rtl/gate_signal_monitor.sv
// Gate signal monitor: per-period on-time and dead-time measurement with shoot-through protection.
// Dead-time counters, dt_min outputs and dead-time fault exist only with GSM_DEADTIME_MEAS_EN.
module gate_signal_monitor #(
    parameter int unsigned CNT_W      = 8,
    parameter logic [4:0]  DT_MIN_REQ = 5'd2
) (
    input  logic             clk,
    input  logic             RST,
    input  logic [3:0]       JE,
    input  logic             period_start,
    input  logic             fault_clr,
    output logic [CNT_W-1:0] duty1,
    output logic [CNT_W-1:0] duty2,
    output logic [4:0]       dt_min1,
    output logic [4:0]       dt_min2,
    output logic             meas_valid,
    output logic             fault,
    output logic [1:0]       fault_code
);
    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StMeasure = 2'd1;
    localparam logic [1:0] StFault   = 2'd2;

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic [3:0]       je_q;
    logic             period_q;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;
    logic [CNT_W-1:0] duty1_q, duty1_d, duty2_q, duty2_d;
    logic             meas_valid_q, meas_valid_d, fault_q;
    logic [1:0]       code_q, code_d, fault_det;
    logic             p1, p2, n1, n2;
    logic             shoot, dt_fault, any_fault;
    logic             period_load, period_restart;

    // Input stage; reset value 4'b0011 means every device off.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            je_q     <= 4'b0011;
            period_q <= 1'b0;
        end else begin
            je_q     <= JE;
            period_q <= period_start;
        end
    end

    assign p1 = ~je_q[0];
    assign p2 = ~je_q[1];
    assign n1 = je_q[2];
    assign n2 = je_q[3];

    assign shoot     = (p1 & n2) | (p2 & n1);
    assign fault_det = {dt_fault, shoot};
    assign any_fault = |fault_det;

    // A fault on a period-start cycle suppresses both the output update and the restart.
    assign period_load    = (state_q == StMeasure) & period_q & ~any_fault;
    assign period_restart = ((state_q == StIdle) | (state_q == StMeasure)) & period_q & ~any_fault;

    always_comb begin
        state_d      = state_q;
        code_d       = code_q;
        cnt1_d       = cnt1_q;
        cnt2_d       = cnt2_q;
        duty1_d      = duty1_q;
        duty2_d      = duty2_q;
        meas_valid_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (any_fault) begin
                    state_d = StFault;
                    code_d  = code_q | fault_det;
                end else if (period_q) begin
                    state_d = StMeasure;
                end
            end
            StMeasure: begin
                if (any_fault) begin
                    state_d = StFault;
                    code_d  = code_q | fault_det;
                end else if (period_q) begin
                    duty1_d      = cnt1_q;
                    duty2_d      = cnt2_q;
                    meas_valid_d = 1'b1;
                end else begin
                    if (p1 && cnt1_q != CntMax) cnt1_d = cnt1_q + 1'b1;
                    if (p2 && cnt2_q != CntMax) cnt2_d = cnt2_q + 1'b1;
                end
            end
            StFault: begin
                code_d = code_q | fault_det;
                // A fault seen together with the clear wins and keeps us here.
                if (fault_clr) begin
                    code_d = fault_det;
                    if (!any_fault) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (period_restart) begin
            cnt1_d = CNT_W'(p1);
            cnt2_d = CNT_W'(p2);
        end
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q      <= StIdle;
            code_q       <= 2'b00;
            cnt1_q       <= '0;
            cnt2_q       <= '0;
            duty1_q      <= '0;
            duty2_q      <= '0;
            meas_valid_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            code_q       <= code_d;
            cnt1_q       <= cnt1_d;
            cnt2_q       <= cnt2_d;
            duty1_q      <= duty1_d;
            duty2_q      <= duty2_d;
            meas_valid_q <= meas_valid_d;
            fault_q      <= (state_d == StFault);
        end
    end

    assign duty1      = duty1_q;
    assign duty2      = duty2_q;
    assign meas_valid = meas_valid_q;
    assign fault      = fault_q;
    assign fault_code = code_q;

`ifdef GSM_DEADTIME_MEAS_EN
    localparam logic [4:0] DtMax = 5'd31;

    logic [4:0] dt_cnt_a_q, dt_cnt_a_d, dt_cnt_b_q, dt_cnt_b_d;
    logic [4:0] min_a_q, min_a_d, min_b_q, min_b_d;
    logic [4:0] dt_min1_q, dt_min1_d, dt_min2_q, dt_min2_d;
    logic       off_a, off_b, exit_a, exit_b;

    // Leg A is pmos1/nmos2, leg B is pmos2/nmos1.
    assign off_a  = ~p1 & ~n2;
    assign off_b  = ~p2 & ~n1;
    assign exit_a = ~off_a & (dt_cnt_a_q != 5'd0);
    assign exit_b = ~off_b & (dt_cnt_b_q != 5'd0);

    assign dt_fault = (state_q == StMeasure) &
                      ((exit_a & (dt_cnt_a_q < DT_MIN_REQ)) | (exit_b & (dt_cnt_b_q < DT_MIN_REQ)));

    always_comb begin
        dt_cnt_a_d = dt_cnt_a_q;
        dt_cnt_b_d = dt_cnt_b_q;
        min_a_d    = min_a_q;
        min_b_d    = min_b_q;
        dt_min1_d  = dt_min1_q;
        dt_min2_d  = dt_min2_q;
        if (state_q != StFault) begin
            dt_cnt_a_d = off_a ? ((dt_cnt_a_q == DtMax) ? DtMax : dt_cnt_a_q + 5'd1) : 5'd0;
            dt_cnt_b_d = off_b ? ((dt_cnt_b_q == DtMax) ? DtMax : dt_cnt_b_q + 5'd1) : 5'd0;
        end
        if (period_load) begin
            dt_min1_d = min_a_q;
            dt_min2_d = min_b_q;
        end
        // An exit on the period-start cycle belongs to the new period.
        if (period_restart) begin
            min_a_d = exit_a ? dt_cnt_a_q : DtMax;
            min_b_d = exit_b ? dt_cnt_b_q : DtMax;
        end else if (state_q == StMeasure && !any_fault) begin
            if (exit_a && dt_cnt_a_q < min_a_q) min_a_d = dt_cnt_a_q;
            if (exit_b && dt_cnt_b_q < min_b_q) min_b_d = dt_cnt_b_q;
        end
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            dt_cnt_a_q <= 5'd0;
            dt_cnt_b_q <= 5'd0;
            min_a_q    <= DtMax;
            min_b_q    <= DtMax;
            dt_min1_q  <= DtMax;
            dt_min2_q  <= DtMax;
        end else begin
            dt_cnt_a_q <= dt_cnt_a_d;
            dt_cnt_b_q <= dt_cnt_b_d;
            min_a_q    <= min_a_d;
            min_b_q    <= min_b_d;
            dt_min1_q  <= dt_min1_d;
            dt_min2_q  <= dt_min2_d;
        end
    end

    assign dt_min1 = dt_min1_q;
    assign dt_min2 = dt_min2_q;
`else
    assign dt_fault = 1'b0;
    assign dt_min1  = 5'd0;
    assign dt_min2  = 5'd0;
`endif

endmodule

// File: tb/tb_gate_signal_monitor.sv
// Randomized bench for gate_signal_monitor: per-period stimulus is generated as arrays of gate
// states and the expected duty/dead-time results are computed from those arrays directly.
module tb_gate_signal_monitor;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef GSM_DEADTIME_MEAS_EN
    localparam bit DT_EN = 1'b1;
`else
    localparam bit DT_EN = 1'b0;
`endif
    localparam int DT_RST = DT_EN ? 31 : 0;

    logic             clk = 1'b0;
    logic             RST;
    logic [3:0]       JE;
    logic             period_start;
    logic             fault_clr;
    logic [CNT_W-1:0] duty1, duty2;
    logic [4:0]       dt_min1, dt_min2;
    logic             meas_valid, fault;
    logic [1:0]       fault_code;

    gate_signal_monitor #(.CNT_W(CNT_W), .DT_MIN_REQ(5'd2)) dut (
        .clk          (clk),
        .RST          (RST),
        .JE           (JE),
        .period_start (period_start),
        .fault_clr    (fault_clr),
        .duty1        (duty1),
        .duty2        (duty2),
        .dt_min1      (dt_min1),
        .dt_min2      (dt_min2),
        .meas_valid   (meas_valid),
        .fault        (fault),
        .fault_code   (fault_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        int d1;
        int d2;
        int t1;
        int t2;
    } meas_t;

    meas_t exp_q[$];
    meas_t prev;
    bit    have_prev;
    int    checks_total  = 0;
    int    checks_passed = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks_total++;
        if (obs == exp) checks_passed++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    // Every meas_valid pulse must match the oldest completed period.
    always @(negedge clk) begin : monitor
        meas_t m;
        if (RST === 1'b1 && meas_valid === 1'b1) begin
            check("meas_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                m = exp_q.pop_front();
                check("duty1", int'(duty1), m.d1);
                check("duty2", int'(duty2), m.d2);
                check("dt_min1", int'(dt_min1), m.t1);
                check("dt_min2", int'(dt_min2), m.t2);
            end
        end
    end

    // One leg over a period: device p on for [s, s+on), n on except within d cycles of p.
    task automatic leg(input int n_cyc, input int s, input int on, input int d, input int k,
                       output bit p, output bit n);
        if (on >= n_cyc) begin
            p = 1'b1;
            n = 1'b0;
        end else if (on == 0) begin
            p = 1'b0;
            n = 1'b1;
        end else begin
            p = (k >= s) && (k < s + on);
            n = (k < s - d) || (k >= s + on + d);
        end
    endtask

    task automatic run_period(input int n_cyc, input int sa, input int ona, input int da,
                              input int sb, input int onb, input int db);
        bit p1, p2, n1, n2;
        int c1 = 0, c2 = 0, run_a = 0, run_b = 0, mn_a = 31, mn_b = 31;
        for (int k = 0; k < n_cyc; k++) begin
            leg(n_cyc, sa, ona, da, k, p1, n2);
            leg(n_cyc, sb, onb, db, k, p2, n1);
            @(posedge clk);
            #1;
            JE           = {n2, n1, ~p2, ~p1};
            period_start = (k == 0);
            if (k == 0 && have_prev) exp_q.push_back(prev);
            c1 += int'(p1);
            c2 += int'(p2);
            if (!p1 && !n2) run_a++;
            else if (run_a > 0) begin
                mn_a  = (run_a < mn_a) ? run_a : mn_a;
                run_a = 0;
            end
            if (!p2 && !n1) run_b++;
            else if (run_b > 0) begin
                mn_b  = (run_b < mn_b) ? run_b : mn_b;
                run_b = 0;
            end
        end
        prev.d1   = (c1 > CNT_MAX) ? CNT_MAX : c1;
        prev.d2   = (c2 > CNT_MAX) ? CNT_MAX : c2;
        prev.t1   = DT_EN ? mn_a : 0;
        prev.t2   = DT_EN ? mn_b : 0;
        have_prev = 1'b1;
    endtask

    // Ends the running period; leaves the DUT measuring a new period with all gates low-side.
    task automatic close_period();
        @(posedge clk);
        #1;
        period_start = 1'b1;
        if (have_prev) exp_q.push_back(prev);
        have_prev = 1'b0;
        @(posedge clk);
        #1;
        period_start = 1'b0;
        JE           = 4'b1111;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("queue_drain", exp_q.size(), 0);
        check("fault_idle", int'(fault), 0);
    endtask

    task automatic rand_leg(input int n_cyc, output int s, output int on, output int d);
        int sel;
        sel = $urandom_range(0, 9);
        d   = $urandom_range(2, 6);
        if (sel == 0) on = 0;
        else if (sel == 1) on = n_cyc;
        else on = $urandom_range(1, n_cyc - 2 * d - 3);
        s = (on > 0 && on < n_cyc) ? $urandom_range(d + 1, n_cyc - 1 - on - d) : 0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_duty1"}, int'(duty1), 0);
        check({tag, "_duty2"}, int'(duty2), 0);
        check({tag, "_dt_min1"}, int'(dt_min1), DT_RST);
        check({tag, "_dt_min2"}, int'(dt_min2), DT_RST);
        check({tag, "_meas_valid"}, int'(meas_valid), 0);
        check({tag, "_fault"}, int'(fault), 0);
        check({tag, "_fault_code"}, int'(fault_code), 0);
    endtask

    task automatic release_reset();
        JE = 4'b1111;
        repeat (3) @(posedge clk);
        #1;
        RST = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        int n, sa, ona, da, sb, onb, db;
        JE           = 4'b1111;
        period_start = 1'b0;
        fault_clr    = 1'b0;
        RST          = 1'b1;
        have_prev    = 1'b0;
        #2;
        RST = 1'b0;
        #1;
        check_reset_values("reset");
        release_reset();

        // Nominal periods, then randomized ones, then full-on and saturation.
        repeat (3) run_period(254, 10, 100, 2, 130, 60, 2);
        for (int i = 0; i < 8; i++) begin
            n = $urandom_range(40, 300);
            rand_leg(n, sa, ona, da);
            rand_leg(n, sb, onb, db);
            run_period(n, sa, ona, da, sb, onb, db);
        end
        run_period(254, 0, 254, 2, 50, 40, 3);
        run_period(300, 0, 300, 2, 60, 90, 4);
        close_period();

        // Shoot-through on leg A for one cycle.
        @(posedge clk);
        #1;
        JE = 4'b1010;
        @(posedge clk);
        #1;
        JE = 4'b1111;
        @(negedge clk);
        check("st_fault_early", int'(fault), 0);
        @(negedge clk);
        check("st_fault", int'(fault), 1);
        check("st_code", int'(fault_code), 1);
        @(posedge clk);
        #1;
        period_start = 1'b1;
        @(posedge clk);
        #1;
        period_start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("st_fault_sticky", int'(fault), 1);

        // Clear coincident with a new shoot-through: fault must remain.
        @(posedge clk);
        #1;
        JE = 4'b1010;
        @(posedge clk);
        #1;
        JE        = 4'b1111;
        fault_clr = 1'b1;
        @(posedge clk);
        #1;
        fault_clr = 1'b0;
        @(negedge clk);
        check("clr_race_fault", int'(fault), 1);
        check("clr_race_code", int'(fault_code), 1);
        repeat (2) @(posedge clk);
        #1;
        fault_clr = 1'b1;
        @(posedge clk);
        #1;
        fault_clr = 1'b0;
        @(negedge clk);
        check("clr_fault", int'(fault), 0);
        check("clr_code", int'(fault_code), 0);
        repeat (3) @(posedge clk);
        run_period(254, 10, 100, 2, 130, 60, 2);
        run_period(200, 20, 50, 3, 90, 70, 2);
        close_period();

        // Asynchronous reset in the middle of a period with pmos1 on.
        @(posedge clk);
        #1;
        JE = 4'b0110;
        repeat (60) @(posedge clk);
        #3;
        RST = 1'b0;
        #1;
        check_reset_values("midreset");
        exp_q.delete();
        have_prev = 1'b0;
        release_reset();
        run_period(120, 10, 40, 2, 60, 30, 3);
        run_period(150, 20, 70, 2, 100, 20, 2);

        // One-cycle dead time on leg B.
        run_period(100, 20, 30, 2, 40, 20, 1);
        if (DT_EN) begin
            have_prev = 1'b0;
            @(negedge clk);
            check("dt_fault", int'(fault), 1);
            check("dt_code", int'(fault_code), 2);
            repeat (5) @(posedge clk);
            check("dt_queue_drain", exp_q.size(), 0);
        end else begin
            close_period();
            check("dt_code_off", int'(fault_code), 0);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule

// File: doc/gate_signal_monitor.md
GATE_SIGNAL_MONITOR -- requirements
Module: gate_signal_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of on-time counters and duty outputs.
REQ-002 SHALL have parameter DT_MIN_REQ, default 5'd2: minimum legal dead time in clk cycles.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port RST  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port JE  input  4  gate signals: [0] pmos1 (active-low), [1] pmos2 (active-low), [2] nmos1 (active-high), [3] nmos2 (active-high).
REQ-006 SHALL have port period_start  input  1  one-cycle pulse marking carrier period start (XADC_Event).
REQ-007 SHALL have port fault_clr  input  1  one-cycle pulse clearing the fault state.
REQ-008 SHALL have port duty1  output  CNT_W  pmos1 on-time of the last complete period, in cycles.
REQ-009 SHALL have port duty2  output  CNT_W  pmos2 on-time of the last complete period, in cycles.
REQ-010 SHALL have port dt_min1  output  5  minimum dead time of leg A (pmos1/nmos2) in the last period.
REQ-011 SHALL have port dt_min2  output  5  minimum dead time of leg B (pmos2/nmos1) in the last period.
REQ-012 SHALL have port meas_valid  output  1  one-cycle pulse when duty/dt outputs update.
REQ-013 SHALL have port fault  output  1  sticky fault flag.
REQ-014 SHALL have port fault_code  output  2  [0] shoot-through, [1] dead-time violation; sticky.

Function
REQ-015 SHALL register JE and period_start once (stage q); all logic SHALL use q values only.
REQ-016 SHALL decode device on-states: p1=~JE_q[0], p2=~JE_q[1], n1=JE_q[2], n2=JE_q[3].
REQ-017 SHALL implement FSM states IDLE, MEASURE, FAULT; reset state IDLE.
REQ-018 IDLE -> MEASURE on period_start_q; no outputs update in IDLE.
REQ-019 In MEASURE, on each cycle with period_start_q=0, SHALL increment cnt1 if p1 and cnt2 if p2, saturating at 2^CNT_W-1.
REQ-020 In MEASURE with period_start_q=1, SHALL load duty1/duty2 from cnt1/cnt2, load dt_min1/dt_min2 from running minima, assert meas_valid next cycle for exactly one cycle, then restart counters at p1/p2 (0 or 1) and minima at 31.
REQ-021 Dead-time counter per leg SHALL count consecutive cycles with both leg devices off, saturating at 31; on exit from both-off, SHALL update running minimum with count if smaller, then clear.
REQ-022 A period with no both-off exit on a leg SHALL report dt_min=31 for that leg.
REQ-023 Shoot-through (p1&n2 or p2&n1 on any cycle) SHALL set fault_code[0] and enter FAULT on the next edge, from IDLE or MEASURE.
REQ-024 A both-off exit with count < DT_MIN_REQ in MEASURE SHALL set fault_code[1] and enter FAULT.
REQ-025 In FAULT, counters SHALL hold, meas_valid SHALL stay 0, and duty/dt outputs SHALL hold last values.
REQ-026 fault_clr in FAULT SHALL clear fault and fault_code and go to IDLE; fault_clr outside FAULT SHALL be ignored.
REQ-027 If fault_clr and a new fault condition occur in the same cycle, the new fault SHALL win (remain in FAULT with new code bits set).
REQ-028 If period_start_q and a fault detection coincide, SHALL enter FAULT without updating outputs or pulsing meas_valid.
REQ-029 fault SHALL equal (state==FAULT), registered.

Reset
REQ-030 RST low SHALL asynchronously force IDLE; duty1, duty2, cnt1, cnt2=0; dt_min1, dt_min2=31; meas_valid, fault, fault_code=0; q stage=JE 4'b0011, period_start 0.
REQ-031 Reset deassertion mid-period SHALL wait in IDLE for the next period_start before measuring.

Configuration
REQ-032 Macro GSM_DEADTIME_MEAS_EN defined SHALL include dead-time counters, dt_min outputs and fault_code[1] detection.
REQ-033 Without GSM_DEADTIME_MEAS_EN, dt_min1/dt_min2 SHALL be tied 0, fault_code[1] SHALL be 0, and the related logic SHALL be absent; shoot-through detection SHALL remain.

Verification
REQ-034 Periods of 254 cycles, p1 on 100 cycles, p2 on 60, dead time 2 each edge -> meas_valid once per period, duty1=100, duty2=60, dt_min1=dt_min2=2, fault=0.
REQ-035 p1 on 254 of 254 cycles (n2 off) -> duty1=254, dt_min1=31; with CNT_W=8 and a 300-cycle period -> duty1=255 (saturated).
REQ-036 JE=4'b1010 (p1 and n2 on) one cycle in MEASURE -> fault=1, fault_code=2'b01 two edges later; meas_valid absent until fault_clr plus next period_start.
REQ-037 Dead time of 1 cycle on leg B, DT_MIN_REQ=2 -> fault_code=2'b10; without GSM_DEADTIME_MEAS_EN same stimulus -> fault=0, dt_min2=0.
REQ-038 RST low mid-period with cnt1=50 -> outputs at reset values immediately; after release, first meas_valid only after second period_start.
REQ-039 fault_clr coincident with a new shoot-through -> remains in FAULT, fault_code[0]=1.
